// File: rtl/fir_scie_pkg.sv
// Shared opcodes and FSM state encoding for the SCIE FIR sequencer.
package fir_scie_pkg;

    // Custom-instruction opcodes understood by the SCIE FIR unit.
    localparam logic [31:0] COEF_WR  = 32'd11;
    localparam logic [31:0] SMP_PUSH = 32'd43;
    localparam logic [31:0] RES_RD   = 32'd91;

    // Sequencer states: coefficient load, then the per-sample push/gap/read/capture walk.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PUSH,
        GAP,
        READ,
        CAP
    } state_t;

endpackage

// File: rtl/fir_res_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero when empty.
module fir_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is only taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: the data array is deliberately not reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Gate the head so the output is a clean zero while empty (including right after reset).
    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_scie_sequencer.sv
// Drives the SCIE FIR unit: coefficient load, per-sample push/gap/read, result buffering.
module fir_scie_sequencer
    import fir_scie_pkg::*;
#(
    parameter int TAPS      = 5,
    parameter int XLEN      = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cfg_start,
    output logic            cfg_busy,
    input  logic            coef_valid,
    output logic            coef_ready,
    input  logic [XLEN-1:0] coef_data,
    input  logic            smp_valid,
    output logic            smp_ready,
    input  logic [XLEN-1:0] smp_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            scie_valid,
    output logic [31:0]     scie_insn,
    output logic [XLEN-1:0] scie_rs1,
    output logic [XLEN-1:0] scie_rs2,
    input  logic [XLEN-1:0] scie_rd
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [XLEN-1:0]   sample, sample_next;
    logic              pending, pending_next;
    logic              coef_loaded, loaded_next;
    logic              fifo_push;
    logic [CNT_W-1:0]  fifo_count;

    // State register plus the index, sample latch, pending-start and loaded flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            sample      <= '0;
            pending     <= 1'b0;
            coef_loaded <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            sample      <= sample_next;
            pending     <= pending_next;
            coef_loaded <= loaded_next;
        end
    end

    // Next-state logic and SCIE/stream handshake outputs.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        sample_next  = sample;
        pending_next = pending;
        loaded_next  = coef_loaded;
        coef_ready   = 1'b0;
        smp_ready    = 1'b0;
        scie_valid   = 1'b0;
        scie_insn    = '0;
        scie_rs1     = '0;
        scie_rs2     = '0;
        fifo_push    = 1'b0;

        // A start request during a sample is remembered and served after its capture.
        if (cfg_start && (state inside {PUSH, GAP, READ})) pending_next = 1'b1;

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end else if (coef_loaded && smp_valid &&
                             (fifo_count < CNT_W'(OUT_DEPTH))) begin
                    // Accepting here reserves the FIFO slot the capture will use.
                    smp_ready   = 1'b1;
                    sample_next = smp_data;
                    state_next  = PUSH;
                end
            end
            LOAD: begin
                coef_ready = 1'b1;
                if (coef_valid) begin
                    scie_valid = 1'b1;
                    scie_insn  = COEF_WR;
                    scie_rs1   = coef_data;
                    scie_rs2   = XLEN'(idx);
                end
                if (cfg_start) begin
                    // A fresh start restarts the table from index 0.
                    idx_next = '0;
                end else if (coef_valid) begin
                    if (idx == LAST_IDX) begin
                        loaded_next = 1'b1;
                        idx_next    = '0;
                        state_next  = IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            PUSH: begin
                scie_valid = 1'b1;
                scie_insn  = SMP_PUSH;
                scie_rs1   = sample;
                state_next = GAP;
            end
            GAP: begin
                state_next = READ;
            end
            READ: begin
                scie_valid = 1'b1;
                scie_insn  = RES_RD;
                state_next = CAP;
            end
            CAP: begin
                fifo_push = 1'b1;
                if (pending || cfg_start) begin
                    state_next   = LOAD;
                    idx_next     = '0;
                    pending_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cfg_busy  = (state != IDLE) || pending;
    assign res_valid = (fifo_count != '0);

    fir_res_fifo #(
        .WIDTH (XLEN),
        .DEPTH (OUT_DEPTH)
    ) u_res_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (scie_rd),
        .pop       (res_valid && res_ready),
        .head      (res_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fir_scie_sequencer.sv
// Scoreboard bench for fir_scie_sequencer with a one-sample-lag SCIE stub.
module tb_fir_scie_sequencer;

    localparam int TAPS  = 5;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clock;
    logic            reset;
    logic            cfg_start;
    logic            cfg_busy;
    logic            coef_valid;
    logic            coef_ready;
    logic [XLEN-1:0] coef_data;
    logic            smp_valid;
    logic            smp_ready;
    logic [XLEN-1:0] smp_data;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            scie_valid;
    logic [31:0]     scie_insn;
    logic [XLEN-1:0] scie_rs1;
    logic [XLEN-1:0] scie_rs2;
    logic [XLEN-1:0] scie_rd = '0;

    fir_scie_sequencer #(.TAPS(TAPS), .XLEN(XLEN), .OUT_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_busy   (cfg_busy),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_data   (smp_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .scie_valid (scie_valid),
        .scie_insn  (scie_insn),
        .scie_rs1   (scie_rs1),
        .scie_rs2   (scie_rs2),
        .scie_rd    (scie_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } txn_t;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    logic [31:0]     exp_q[$];
    txn_t            log_q[$];
    logic [31:0]     coef_vals[TAPS] = '{32'd10, 32'd91, 32'd85, 32'd99, 32'd83};
    logic [31:0]     model_prev = '0;
    logic [31:0]     stub_last = '0;
    logic [31:0]     stub_prev = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // SCIE stub: a read returns the operand of the push before the most recent one.
    always @(posedge clock) begin
        if (scie_valid && scie_insn == 32'd43) begin
            stub_prev <= stub_last;
            stub_last <= scie_rs1;
        end
        if (scie_valid && scie_insn == 32'd91) scie_rd <= stub_prev;
    end

    // Monitor: result scoreboard, SCIE transaction log, idle-insn check.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (scie_valid) log_q.push_back('{cyc, scie_insn, scie_rs1, scie_rs2});
            n_cmp++;
            if (!scie_valid && scie_insn !== 32'd0) begin
                n_bad++;
                $display("FAIL idle_insn: got %0d expected 0", scie_insn);
            end
            if (res_valid && res_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL result_unexpected: got %0d expected none", res_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (res_data !== e) begin
                        n_bad++;
                        $display("FAIL result: got %0d expected %0d", res_data, e);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(posedge clock); #1;
        cfg_start = 1'b0;
    endtask

    task automatic feed_coefs(input int first, input int n, input bit stall);
        for (int i = first; i < first + n; i++) begin
            bit got;
            got = 1'b0;
            coef_valid = 1'b1;
            coef_data  = coef_vals[i];
            for (int t = 0; t < 20; t++) begin
                @(negedge clock);
                if (coef_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL coef_timeout: got ready=0 expected ready=1 at idx %0d", i);
            end
            @(posedge clock); #1;
            coef_valid = 1'b0;
            if (stall && i == 2) begin
                @(negedge clock);
                n_cmp++;
                if (scie_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL coef_stall: got scie_valid=%0b expected 0", scie_valid);
                end
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic send_sample(input logic [31:0] d, output int acc);
        acc = -1;
        smp_valid = 1'b1;
        smp_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (smp_ready) begin
                @(posedge clock);
                acc = cyc;
                #1;
                break;
            end
        end
        smp_valid = 1'b0;
        n_cmp++;
        if (acc < 0) begin
            n_bad++;
            $display("FAIL sample_timeout: got no accept expected accept of %0d", d);
        end else begin
            exp_q.push_back(model_prev);
            model_prev = d;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_start = 0; coef_valid = 0; coef_data = '0;
        smp_valid = 0; smp_data = '0; res_ready = 0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({cfg_busy, coef_ready, smp_ready, res_valid, scie_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {cfg_busy, coef_ready, smp_ready, res_valid, scie_valid});
        end
        n_cmp++;
        if ({res_data, scie_insn, scie_rs1, scie_rs2} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 0", {res_data, scie_insn, scie_rs1, scie_rs2});
        end
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_no_coef();
        int bad;
        bad = 0;
        smp_valid = 1'b1;
        smp_data  = 32'd55;
        repeat (10) begin
            @(negedge clock);
            if (smp_ready || scie_valid) bad++;
        end
        smp_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL no_coef_refuse: got %0d active cycles expected 0", bad);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_coef_load();
        log_q.delete();
        pulse_start();
        feed_coefs(0, TAPS, 1'b1);
        @(negedge clock);
        n_cmp++;
        if (coef_ready !== 1'b0 || cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL load_done: got ready=%0b busy=%0b expected 0 0", coef_ready, cfg_busy);
        end
        n_cmp++;
        if (log_q.size() != TAPS) begin
            n_bad++;
            $display("FAIL load_count: got %0d expected %0d", log_q.size(), TAPS);
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                n_cmp++;
                if (log_q[i].insn !== 32'd11 || log_q[i].rs1 !== coef_vals[i] ||
                    log_q[i].rs2 !== 32'(i)) begin
                    n_bad++;
                    $display("FAIL load_txn: got (%0d,%0d,%0d) expected (11,%0d,%0d)",
                             log_q[i].insn, log_q[i].rs1, log_q[i].rs2, coef_vals[i], i);
                end
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_samples();
        logic [31:0] s[5] = '{32'd85, 32'd30, 32'd31, 32'd1, 32'd94};
        int acc[5];
        res_ready = 1'b1;
        log_q.delete();
        for (int k = 0; k < 5; k++) send_sample(s[k], acc[k]);
        wait_drain();
        for (int k = 1; k < 5; k++) begin
            n_cmp++;
            if (acc[k] - acc[k-1] != 5) begin
                n_bad++;
                $display("FAIL spacing: got %0d expected 5", acc[k] - acc[k-1]);
            end
        end
        n_cmp++;
        if (log_q.size() != 10) begin
            n_bad++;
            $display("FAIL insn_count: got %0d expected 10", log_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (log_q[2*k].insn !== 32'd43 || log_q[2*k].rs1 !== s[k] ||
                    log_q[2*k].rs2 !== 32'd0 || log_q[2*k+1].insn !== 32'd91 ||
                    log_q[2*k+1].cyc - log_q[2*k].cyc != 2) begin
                    n_bad++;
                    $display("FAIL insn_seq: got (%0d,%0d,%0d gap %0d) expected (43,%0d,91 gap 2)",
                             log_q[2*k].insn, log_q[2*k].rs1, log_q[2*k+1].insn,
                             log_q[2*k+1].cyc - log_q[2*k].cyc, s[k]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int acc;
        int n;
        res_ready = 1'b0;
        send_sample(32'd77, acc);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            n++;
            if (res_valid) break;
        end
        n_cmp++;
        if (n != 5) begin
            n_bad++;
            $display("FAIL latency: got %0d expected 5", n);
        end
        n_cmp++;
        if (exp_q.size() == 0 || res_data !== exp_q[0]) begin
            n_bad++;
            $display("FAIL latency_head: got %0d expected %0d", res_data,
                     (exp_q.size() != 0) ? exp_q[0] : 32'd0);
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back_full();
        logic [31:0] s[6] = '{32'd200, 32'd201, 32'd202, 32'd203, 32'd204, 32'd205};
        int acc;
        int seen;
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_sample(s[k], acc);
        smp_valid = 1'b1;
        smp_data  = s[4];
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (smp_ready) seen++;
        end
        n_cmp++;
        if (seen != 0 || res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL full_refuse: got %0d ready cycles valid=%0b expected 0 1", seen, res_valid);
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
        send_sample(s[4], acc);
        send_sample(s[5], acc);
        wait_drain();
    endtask

    task automatic test_cfg_in_gap();
        int acc;
        int bad;
        bad = 0;
        res_ready = 1'b1;
        send_sample(32'd66, acc);
        @(posedge clock); #1;                       // now in GAP
        cfg_start = 1'b1;
        @(negedge clock);
        if (cfg_busy !== 1'b1) bad++;
        @(posedge clock); #1;                       // READ
        cfg_start = 1'b0;
        @(negedge clock);
        if (cfg_busy !== 1'b1 || coef_ready !== 1'b0) bad++;
        @(negedge clock);                           // CAP
        if (cfg_busy !== 1'b1 || coef_ready !== 1'b0) bad++;
        @(negedge clock);                           // LOAD
        n_cmp++;
        if (bad != 0 || coef_ready !== 1'b1 || cfg_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_in_gap: got %0d early errs ready=%0b busy=%0b expected 0 1 1",
                     bad, coef_ready, cfg_busy);
        end
        @(posedge clock); #1;
        feed_coefs(0, TAPS, 1'b0);
        wait_drain();
    endtask

    task automatic test_reset_mid_load();
        int acc;
        int seen;
        pulse_start();
        feed_coefs(0, 2, 1'b0);
        coef_valid = 1'b1;
        coef_data  = coef_vals[2];
        @(negedge clock);
        n_cmp++;
        if (scie_valid !== 1'b1 || scie_rs2 !== 32'd2) begin
            n_bad++;
            $display("FAIL mid_load_idx: got valid=%0b idx=%0d expected 1 2", scie_valid, scie_rs2);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({cfg_busy, coef_ready, smp_ready, res_valid, scie_valid, res_data,
             scie_insn, scie_rs1, scie_rs2} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy=%0b ready=%0b valid=%0b insn=%0d expected all 0",
                     cfg_busy, coef_ready, scie_valid, scie_insn);
        end
        coef_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        smp_valid = 1'b1;
        smp_data  = 32'd123;
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (smp_ready) seen++;
        end
        smp_valid = 1'b0;
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL refuse_after_reset: got %0d ready cycles expected 0", seen);
        end
        @(posedge clock); #1;
        pulse_start();
        feed_coefs(0, TAPS, 1'b0);
        res_ready = 1'b1;
        send_sample(32'd321, acc);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_no_coef();
        test_coef_load();
        test_samples();
        test_latency();
        test_back_to_back_full();
        test_cfg_in_gap();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
